// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state encoding and message byte lookup for the status transmitter
package uart_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, SEND_BYTE, NEXT, DONE} state_t;

   localparam logic [7:0] ASCII_O  = 8'h4F;
   localparam logic [7:0] ASCII_K  = 8'h4B;
   localparam logic [7:0] ASCII_E  = 8'h45;
   localparam logic [7:0] ASCII_R  = 8'h52;
   localparam logic [7:0] ASCII_L  = 8'h4C;
   localparam logic [7:0] ASCII_EQ = 8'h3D;
   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_1  = 8'h31;
   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   localparam logic [3:0] ACK_LAST    = 4'd3;
   localparam logic [3:0] REPORT_LAST = 4'd11;
   localparam logic [3:0] STOP_BIT    = 4'd9;

   function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

   // Report bytes 2..9 carry the LEDs MSB first, so byte index 2 maps to led bit 7.
   function automatic logic [7:0] msg_byte(input logic is_ack, input logic ok,
                                           input logic [7:0] leds, input logic [3:0] idx);
      logic [7:0] b;
      logic [2:0] led_sel;
      b = ASCII_LF;
      led_sel = 3'(4'd9 - idx);
      if (is_ack) begin
         case (idx)
            4'd0:    b = ok ? ASCII_O : ASCII_E;
            4'd1:    b = ok ? ASCII_K : ASCII_R;
            4'd2:    b = ASCII_CR;
            default: b = ASCII_LF;
         endcase
      end else begin
         case (idx)
            4'd0:    b = ASCII_L;
            4'd1:    b = ASCII_EQ;
            4'd10:   b = ASCII_CR;
            4'd11:   b = ASCII_LF;
            default: b = leds[led_sel] ? ASCII_1 : ASCII_0;
         endcase
      end
      return b;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer that can chain a new start bit directly after its stop bit
module uart_tx_byte
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 50
) (
   input  logic       i_Clock,
   input  logic       i_Rst,
   input  logic       i_Start,
   input  logic [7:0] i_Data,
   output logic       o_TXD,
   output logic       o_Busy,
   output logic       o_Done
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_EARLY = CNT_W'(CLKS_PER_BIT - 3);

   logic             active;
   logic [3:0]       bit_idx;
   logic [CNT_W-1:0] baud_cnt;
   logic [7:0]       shreg;
   logic             txd;
   logic             in_stop;
   logic             last_cycle;

   // Busy drops in the final stop cycle so a chained start lands with no gap;
   // done fires two cycles earlier to cover the sequencer's NEXT and LOAD cycles.
   assign in_stop    = active && (bit_idx == STOP_BIT);
   assign last_cycle = in_stop && (baud_cnt == CNT_LAST);
   assign o_Busy     = active && !last_cycle;
   assign o_Done     = in_stop && (baud_cnt == CNT_EARLY);
   assign o_TXD      = txd;

   always_ff @(posedge i_Clock or posedge i_Rst) begin
      if (i_Rst) begin
         active   <= 1'b0;
         bit_idx  <= '0;
         baud_cnt <= '0;
         shreg    <= '0;
         txd      <= 1'b1;
      end else if (i_Start && !o_Busy) begin
         active   <= 1'b1;
         bit_idx  <= '0;
         baud_cnt <= '0;
         shreg    <= i_Data;
         txd      <= 1'b0;
      end else if (active) begin
         if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == STOP_BIT) begin
               active  <= 1'b0;
               bit_idx <= '0;
            end else begin
               // Ones shifted in from the top become the stop bit after the 8th shift.
               bit_idx <= bit_idx + 4'd1;
               txd     <= shreg[0];
               shreg   <= {1'b1, shreg[7:1]};
            end
         end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/uart_status_tx.sv
// rtl/uart_status_tx.sv - message sequencer sending OK/ER acknowledges and LED reports over a UART line
module uart_status_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 1_000_000
) (
   input  logic       i_Clock,
   input  logic       i_Rst,
   input  logic       i_Ack_Valid,
   input  logic       i_Ack_Ok,
   input  logic       i_Report,
   input  logic [7:0] i_LEDs,
   output logic       o_TXD,
   output logic       o_Busy,
   output logic       o_Done
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);

   state_t     state, state_next;
   logic       ack_pend, ack_ok_q, rep_pend;
   logic [7:0] rep_leds_q;
   logic       cur_ack, cur_ok;
   logic [7:0] cur_leds;
   logic [3:0] byte_idx;
   logic       ack_req, ack_val, rep_req;
   logic [7:0] rep_val;
   logic       launch, take_ack, take_rep, last_byte;
   logic       byte_start, byte_busy, byte_done;
   logic [7:0] byte_data;

   // A live request overrides the stored sample so the newest value always wins.
   assign ack_req   = ack_pend | i_Ack_Valid;
   assign ack_val   = i_Ack_Valid ? i_Ack_Ok : ack_ok_q;
   assign rep_req   = rep_pend | i_Report;
   assign rep_val   = i_Report ? i_LEDs : rep_leds_q;
   assign launch    = ((state == IDLE) || (state == DONE)) && (ack_req || rep_req);
   assign take_ack  = launch && ack_req;
   assign take_rep  = launch && !ack_req;
   assign last_byte = (byte_idx == (cur_ack ? ACK_LAST : REPORT_LAST));
   assign byte_data = msg_byte(cur_ack, cur_ok, cur_leds, byte_idx);

   always_ff @(posedge i_Clock or posedge i_Rst) begin
      if (i_Rst) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      byte_start = 1'b0;
      o_Busy     = (state != IDLE);
      o_Done     = 1'b0;
      case (state)
         IDLE:      if (launch) state_next = LOAD;
         LOAD: begin
            if (!byte_busy) begin
               byte_start = 1'b1;
               state_next = SEND_BYTE;
            end
         end
         SEND_BYTE: if (byte_done) state_next = NEXT;
         NEXT: begin
            if (!last_byte)      state_next = LOAD;
            else if (!byte_busy) state_next = DONE;
         end
         DONE: begin
            o_Done     = 1'b1;
            // Going straight to LOAD keeps back-to-back messages within two idle cycles.
            state_next = launch ? LOAD : IDLE;
         end
         default:   state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_Clock or posedge i_Rst) begin
      if (i_Rst) begin
         ack_pend   <= 1'b0;
         ack_ok_q   <= 1'b0;
         rep_pend   <= 1'b0;
         rep_leds_q <= '0;
         cur_ack    <= 1'b0;
         cur_ok     <= 1'b0;
         cur_leds   <= '0;
         byte_idx   <= '0;
      end else begin
         ack_pend <= ack_req && !take_ack;
         rep_pend <= rep_req && !take_rep;
         if (i_Ack_Valid) ack_ok_q   <= i_Ack_Ok;
         if (i_Report)    rep_leds_q <= i_LEDs;
         if (launch) begin
            cur_ack  <= take_ack;
            cur_ok   <= ack_val;
            cur_leds <= rep_val;
            byte_idx <= '0;
         end else if ((state == NEXT) && !last_byte) begin
            byte_idx <= byte_idx + 4'd1;
         end
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx_byte (
      .i_Clock (i_Clock),
      .i_Rst   (i_Rst),
      .i_Start (byte_start),
      .i_Data  (byte_data),
      .o_TXD   (o_TXD),
      .o_Busy  (byte_busy),
      .o_Done  (byte_done)
   );

endmodule

// File: tb/tb_uart_status_tx.sv
// tb/tb_uart_status_tx.sv - randomized scoreboard bench decoding the serial line of uart_status_tx
module tb_uart_status_tx;

   localparam int CLKS = 50;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ack_valid = 1'b0;
   logic       ack_ok = 1'b0;
   logic       report = 1'b0;
   logic [7:0] leds = 8'h00;
   logic       txd, busy, done;

   int         total = 0;
   int         bad = 0;
   int         done_cnt = 0;
   logic [7:0] exp_q[$];

   uart_status_tx #(
      .CLK_FREQ (50_000_000),
      .BAUD_RATE(1_000_000)
   ) dut (
      .i_Clock    (clk),
      .i_Rst      (rst),
      .i_Ack_Valid(ack_valid),
      .i_Ack_Ok   (ack_ok),
      .i_Report   (report),
      .i_LEDs     (leds),
      .o_TXD      (txd),
      .o_Busy     (busy),
      .o_Done     (done)
   );

   always #10 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void push_str(input string s);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
   endfunction

   function automatic void expect_ack(input logic ok);
      if (ok) push_str("OK\r\n");
      else    push_str("ER\r\n");
   endfunction

   function automatic void expect_report(input logic [7:0] l);
      string s;
      s = "L=";
      for (int i = 7; i >= 0; i--) begin
         if (l[i]) s = {s, "1"};
         else      s = {s, "0"};
      end
      s = {s, "\r\n"};
      push_str(s);
   endfunction

   task automatic skip(input int n, inout bit ab);
      for (int k = 0; k < n && !ab; k++) begin
         @(negedge clk);
         if (rst) ab = 1'b1;
      end
   endtask

   // Line monitor: decodes each 8N1 frame at mid-bit and checks it against the queue.
   initial begin : monitor
      logic [7:0] got;
      logic       start_lvl, stop_lvl;
      bit         ab;
      forever begin
         @(negedge clk);
         if (!rst && txd === 1'b0) begin
            ab = 1'b0;
            skip(CLKS / 2, ab);
            start_lvl = txd;
            for (int i = 0; i < 8; i++) begin
               skip(CLKS, ab);
               got[i] = txd;
            end
            skip(CLKS, ab);
            stop_lvl = txd;
            if (!ab) begin
               chk("start_bit", start_lvl, 0);
               chk("stop_bit", stop_lvl, 1);
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_byte: got 0x%02h expected none", got);
               end else begin
                  chk("line_byte", got, exp_q.pop_front());
               end
            end
         end
      end
   end

   task automatic wait_low(input int limit, output int cyc, output bit found);
      cyc = 0;
      found = 1'b0;
      while (cyc < limit && !found) begin
         @(negedge clk);
         cyc++;
         if (txd === 1'b0) found = 1'b1;
      end
   endtask

   task automatic wait_done(input int limit, output int cyc, output bit found);
      cyc = 0;
      found = 1'b0;
      while (cyc < limit && !found) begin
         @(negedge clk);
         cyc++;
         if (done === 1'b1) found = 1'b1;
      end
   endtask

   task automatic send_ack(input logic ok);
      @(negedge clk);
      ack_valid = 1'b1;
      ack_ok = ok;
      expect_ack(ok);
      @(negedge clk);
      ack_valid = 1'b0;
      ack_ok = ~ok;
   endtask

   task automatic pulse_report(input logic [7:0] l, input bit push);
      @(negedge clk);
      report = 1'b1;
      leds = l;
      if (push) expect_report(l);
      @(negedge clk);
      report = 1'b0;
      leds = ~l;
   endtask

   task automatic timed_msg(input int exp_cycles, input string name);
      int c;
      bit f;
      wait_low(10, c, f);
      chk({name, "_start_latency"}, c, 1);
      wait_done(exp_cycles + 100, c, f);
      chk({name, "_done_seen"}, f, 1);
      chk({name, "_cycles"}, c, exp_cycles);
      chk({name, "_busy_in_done"}, busy, 1);
      @(negedge clk);
      chk({name, "_busy_after"}, busy, 0);
      chk({name, "_idle_line"}, txd, 1);
   endtask

   task automatic pair_tail(input string name);
      int c, g, blow;
      bit f;
      wait_done(9000, c, f);
      chk({name, "_first_done"}, f, 1);
      g = 0;
      blow = 0;
      while (txd !== 1'b0 && g < 10) begin
         @(negedge clk);
         g++;
         if (busy !== 1'b1) blow++;
      end
      chk({name, "_gap_le2"}, (g <= 2), 1);
      chk({name, "_busy_gap_le2"}, (blow <= 2), 1);
      wait_done(6100, c, f);
      chk({name, "_report_cycles"}, c, 6000);
   endtask

   initial begin : watchdog
      repeat (100000) @(posedge clk);
      bad++;
      $display("FAIL watchdog: simulation did not complete within the cycle budget");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : stim
      int  d0, lows, busys;
      int  c;
      bit  f;
      logic [7:0] a, b;
      logic ok;

      repeat (3) @(negedge clk);
      chk("reset_txd", txd, 1);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      rst = 1'b0;
      lows = 0;
      busys = 0;
      repeat (250) begin
         @(negedge clk);
         if (txd !== 1'b1) lows++;
         if (busy !== 1'b0) busys++;
      end
      chk("idle_txd_low_cycles", lows, 0);
      chk("idle_busy_cycles", busys, 0);
      chk("idle_done_pulses", done_cnt, 0);

      d0 = done_cnt;
      send_ack(1'b1);
      chk("accept_busy", busy, 1);
      chk("accept_txd_high", txd, 1);
      timed_msg(2000, "ack_ok");
      repeat (5) @(negedge clk);
      chk("ack_ok_done_count", done_cnt - d0, 1);

      for (int n = 0; n < 3; n++) begin
         a = (n == 0) ? 8'b1000_0011 : 8'($urandom);
         d0 = done_cnt;
         pulse_report(a, 1'b1);
         fork
            begin
               repeat (1000) @(negedge clk);
               leds = 8'($urandom);
            end
         join_none
         timed_msg(6000, "report");
         repeat (5) @(negedge clk);
         chk("report_done_count", done_cnt - d0, 1);
      end

      ok = 1'b0;
      for (int n = 0; n < 2; n++) begin
         a = 8'($urandom);
         d0 = done_cnt;
         @(negedge clk);
         ack_valid = 1'b1;
         ack_ok = ok;
         report = 1'b1;
         leds = a;
         expect_ack(ok);
         expect_report(a);
         @(negedge clk);
         ack_valid = 1'b0;
         report = 1'b0;
         leds = ~a;
         ack_ok = ~ok;
         pair_tail("same_cycle");
         repeat (5) @(negedge clk);
         chk("same_cycle_done_count", done_cnt - d0, 2);
         ok = 1'($urandom);
      end

      for (int n = 0; n < 2; n++) begin
         a = (n == 0) ? 8'h01 : 8'($urandom);
         b = (n == 0) ? 8'h02 : 8'($urandom);
         d0 = done_cnt;
         send_ack(1'($urandom));
         repeat (300) @(negedge clk);
         pulse_report(a, 1'b0);
         repeat (300) @(negedge clk);
         pulse_report(b, 1'b1);
         pair_tail("pending_report");
         repeat (5) @(negedge clk);
         chk("pending_done_count", done_cnt - d0, 2);
      end

      send_ack(1'($urandom));
      wait_low(10, c, f);
      chk("abort_msg_started", f, 1);
      repeat (775) @(negedge clk);
      #3 rst = 1'b1;
      #1;
      chk("abort_txd_high", txd, 1);
      chk("abort_busy_low", busy, 0);
      chk("abort_done_low", done, 0);
      d0 = done_cnt;
      repeat (5) @(negedge clk);
      exp_q.delete();
      rst = 1'b0;
      repeat (200) @(negedge clk);
      chk("abort_no_done", done_cnt - d0, 0);
      chk("abort_line_idle", txd, 1);
      send_ack(1'($urandom));
      timed_msg(2000, "post_reset_ack");

      repeat (100) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
